cut_position_generator: RTL and testbench

//  Keyed PRNG supplying the per-line raw_cut_position to line_rotator (scrambler MODE 0 or descrambler MODE 1).

---
 rtl/scrambler_pkg.sv | 16 +
 rtl/galois_lfsr.sv | 32 +++
 rtl/cut_position_generator.sv | 146 ++++++++++++++
 tb/tb_cut_position_generator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/scrambler_pkg.sv
// Shared definitions for the scrambler/descrambler datapath.
package scrambler_pkg;

  localparam int unsigned LFSR_WIDTH = 32;
  localparam int unsigned OUT_WIDTH  = 8;

  localparam logic [LFSR_WIDTH-1:0] POLY       = 32'h80200003;
  localparam logic [LFSR_WIDTH-1:0] RESET_SEED = 32'hACE12024;
  localparam logic [LFSR_WIDTH-1:0] FIELD_SALT = 32'h5A5AA5A5;

  typedef enum logic {
    IDLE,
    STEP
  } fsm_state_t;

endpackage

// File: rtl/galois_lfsr.sv
// Galois LFSR: single step per enabled cycle, parallel load has priority.
module galois_lfsr #(
  parameter int unsigned         WIDTH       = 32,
  parameter logic [WIDTH-1:0]    POLY        = 32'h80200003,
  parameter logic [WIDTH-1:0]    RESET_VALUE = 32'hACE12024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             step_en,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state
);

  // One Galois shift: feedback mask applied when the bit shifted out is 1.
  always_comb begin
    next_state = {1'b0, state[WIDTH-1:1]} ^ (state[0] ? POLY : '0);
  end

  // State register: reset, then load, then step.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RESET_VALUE;
    end else if (load) begin
      state <= load_value;
    end else if (step_en) begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/cut_position_generator.sv
// Keyed per-line cut position PRNG, reseeded at every field start.
module cut_position_generator
  import scrambler_pkg::*;
#(
  parameter int unsigned                  LFSR_WIDTH     = scrambler_pkg::LFSR_WIDTH,
  parameter int unsigned                  OUT_WIDTH      = scrambler_pkg::OUT_WIDTH,
  parameter int unsigned                  STEPS          = 8,
  parameter logic [LFSR_WIDTH-1:0]        POLY           = scrambler_pkg::POLY,
  parameter logic [LFSR_WIDTH-1:0]        RESET_SEED     = scrambler_pkg::RESET_SEED,
  parameter logic [LFSR_WIDTH-1:0]        FIELD_SALT     = scrambler_pkg::FIELD_SALT,
  parameter int unsigned                  LINE_IDX_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      H,
  input  logic                      V,
  input  logic                      F,
  input  logic [LFSR_WIDTH-1:0]     key,
  input  logic                      key_load,
  output logic [OUT_WIDTH-1:0]      cut_position,
  output logic                      cut_valid,
  output logic [LINE_IDX_WIDTH-1:0] line_index,
  output logic                      overrun
);

  localparam int unsigned CNT_WIDTH = 8;

  logic                  prev_h;
  logic                  prev_v;
  logic                  h_rise;
  logic                  v_rise;
  logic [LFSR_WIDTH-1:0] shadow_key;
  logic [LFSR_WIDTH-1:0] active_key;
  logic [LFSR_WIDTH-1:0] active_key_next;
  logic [LFSR_WIDTH-1:0] salted_seed;
  logic [LFSR_WIDTH-1:0] reseed_value;
  logic [LFSR_WIDTH-1:0] lfsr_state;
  logic [LFSR_WIDTH-1:0] lfsr_next;
  logic [CNT_WIDTH-1:0]  step_cnt;
  logic                  start_step;
  logic                  last_step;
  fsm_state_t            fsm;
  fsm_state_t            fsm_next;

  // Edge detection and reseed value; a key_load coinciding with the field
  // start bypasses the shadow so the new key takes effect this field.
  always_comb begin
    h_rise          = H & ~prev_h;
    v_rise          = V & ~prev_v;
    active_key_next = active_key;
    if (v_rise) begin
      active_key_next = key_load ? key : shadow_key;
    end
    salted_seed  = active_key_next ^ (F ? FIELD_SALT : '0);
    reseed_value = (salted_seed == '0) ? LFSR_WIDTH'(1) : salted_seed;
  end

  galois_lfsr #(
    .WIDTH       (LFSR_WIDTH),
    .POLY        (POLY),
    .RESET_VALUE (RESET_SEED)
  ) u_lfsr (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (v_rise),
    .load_value (reseed_value),
    .step_en    (fsm == STEP),
    .state      (lfsr_state),
    .next_state (lfsr_next)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_next;
    end
  end

  // Next-state logic; field start aborts any line in progress.
  always_comb begin
    fsm_next   = fsm;
    start_step = 1'b0;
    last_step  = 1'b0;
    if (v_rise) begin
      fsm_next = IDLE;
    end else begin
      case (fsm)
        IDLE: begin
          if (h_rise && !V) begin
            fsm_next   = STEP;
            start_step = 1'b1;
          end
        end
        STEP: begin
          if (step_cnt == CNT_WIDTH'(STEPS - 1)) begin
            fsm_next  = IDLE;
            last_step = 1'b1;
          end
        end
        default: fsm_next = IDLE;
      endcase
    end
  end

  // Sync history, keys, step/line counters, output and overrun flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_h       <= 1'b0;
      prev_v       <= 1'b0;
      shadow_key   <= RESET_SEED;
      active_key   <= RESET_SEED;
      step_cnt     <= '0;
      cut_position <= '0;
      cut_valid    <= 1'b0;
      line_index   <= '0;
      overrun      <= 1'b0;
    end else begin
      prev_h     <= H;
      prev_v     <= V;
      active_key <= active_key_next;
      cut_valid  <= last_step;
      if (key_load) begin
        shadow_key <= key;
      end
      if (start_step) begin
        step_cnt <= '0;
      end else if (fsm == STEP) begin
        step_cnt <= step_cnt + 1'b1;
      end
      if (last_step) begin
        cut_position <= lfsr_next[OUT_WIDTH-1:0];
      end
      if (v_rise) begin
        line_index <= '0;
      end else if (last_step) begin
        line_index <= line_index + 1'b1;
      end
      if (h_rise && fsm == STEP && !v_rise) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cut_position_generator.sv
// Scoreboard bench for cut_position_generator.
module tb_cut_position_generator;

  localparam logic [31:0] T_POLY  = 32'h80200003;
  localparam logic [31:0] T_SEED  = 32'hACE12024;
  localparam logic [31:0] T_SALT  = 32'h5A5AA5A5;
  localparam int          T_STEPS = 8;

  typedef struct {
    logic [7:0] cut;
    logic [9:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        H, V, F;
  logic [31:0] key;
  logic        key_load;
  logic [7:0]  cut_position;
  logic        cut_valid;
  logic [9:0]  line_index;
  logic        overrun;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  exp_t        exp_q[$];

  logic [31:0] m_state, m_shadow, m_active;
  logic [9:0]  m_idx;

  cut_position_generator dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .H            (H),
    .V            (V),
    .F            (F),
    .key          (key),
    .key_load     (key_load),
    .cut_position (cut_position),
    .cut_valid    (cut_valid),
    .line_index   (line_index),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] galois(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ T_POLY) : (s >> 1);
  endfunction

  task automatic model_reset();
    m_state  = T_SEED;
    m_shadow = T_SEED;
    m_active = T_SEED;
    m_idx    = '0;
    exp_q.delete();
  endtask

  task automatic model_reseed(input logic f);
    logic [31:0] s;
    m_active = m_shadow;
    s = m_active ^ (f ? T_SALT : 32'h0);
    m_state = (s == 32'h0) ? 32'h1 : s;
    m_idx = '0;
  endtask

  // Field start; optional key_load in the same cycle as the V rise.
  task automatic do_vsync(input logic f, input logic load, input logic [31:0] k);
    F = f; key = k; key_load = load; V = 1'b1;
    if (load) m_shadow = k;
    model_reseed(f);
    tick();
    key_load = 1'b0; V = 1'b0;
    tick();
  endtask

  task automatic do_key_load(input logic [31:0] k);
    key = k; key_load = 1'b1;
    m_shadow = k;
    tick();
    key_load = 1'b0;
  endtask

  // One active line; second_rise>0 injects another H rise that many cycles later.
  task automatic do_line(input string tag, input int second_rise);
    exp_t e;
    int   hit;
    for (int i = 0; i < T_STEPS; i++) m_state = galois(m_state);
    m_idx = m_idx + 1'b1;
    e.cut = m_state[7:0];
    e.idx = m_idx;
    exp_q.push_back(e);
    H = 1'b1;
    hit = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 1) H = 1'b0;
      if (second_rise > 0 && i == second_rise) H = 1'b1;
      if (second_rise > 0 && i == second_rise + 1) H = 1'b0;
      if (cut_valid === 1'b1) begin
        hit = i;
        break;
      end
    end
    check({tag, "_latency"}, hit, T_STEPS + 1);
    tick();
    check({tag, "_valid_pulse"}, cut_valid, 1'b0);
  endtask

  // Scoreboard: every cut_valid pulse must match the oldest expected line.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && cut_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cut", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_cut", cut_position, e.cut);
        check("sb_line_index", line_index, e.idx);
      end
    end
  end

  initial begin
    reset_n = 1'b0; H = 1'b1; V = 1'b1; F = 1'b0; key = '0; key_load = 1'b0;
    model_reset();

    // Reset with H=V=1 held; V edge on release reseeds using F=1.
    repeat (3) tick();
    check("rst_cut", cut_position, 8'h00);
    check("rst_valid", cut_valid, 1'b0);
    check("rst_line_index", line_index, 10'd0);
    check("rst_overrun", overrun, 1'b0);
    F = 1'b1;
    reset_n = 1'b1;
    model_reseed(1'b1);
    tick();
    V = 1'b0; H = 1'b0;
    repeat (3) tick();
    check("vh_ignored_index", line_index, 10'd0);
    do_line("rst_vedge", 0);

    // Reset with H held high and V low: H edge starts a line at once.
    reset_n = 1'b0; H = 1'b1; V = 1'b0; F = 1'b0;
    repeat (3) tick();
    model_reset();
    reset_n = 1'b1;
    do_line("rst_hedge", 0);

    // Key 1, even field: known state after eight steps.
    do_key_load(32'h1);
    do_vsync(1'b0, 1'b0, 32'h0);
    do_line("key1", 0);
    check("key1_state", dut.u_lfsr.state, 32'hDB36C002);
    check("key1_cut", cut_position, 8'h02);
    check("key1_index", line_index, 10'd1);

    // Zero seed is replaced by 1 (key loaded with bypass on the V rise).
    do_vsync(1'b0, 1'b1, 32'h0);
    do_line("zero", 0);
    check("zero_cut", cut_position, 8'h02);

    // Second H rise during stepping sets overrun and is dropped.
    do_vsync(1'b0, 1'b0, 32'h0);
    check("ovr_before", overrun, 1'b0);
    do_line("ovr", 4);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_index", line_index, 10'd1);
    repeat (12) tick();
    check("ovr_no_extra", exp_q.size(), 0);

    // Mid-field key load leaves the current field's sequence untouched.
    do_vsync(1'b1, 1'b1, 32'h12345678);
    do_line("mid_a", 0);
    do_key_load(32'hCAFEF00D);
    do_line("mid_b", 0);
    do_line("mid_c", 0);
    do_vsync(1'b0, 1'b0, 32'h0);
    do_line("mid_new", 0);

    // Simultaneous V and H rise: reseed only.
    F = 1'b0; V = 1'b1; H = 1'b1;
    model_reseed(1'b0);
    tick();
    V = 1'b0; H = 1'b0;
    repeat (12) tick();
    check("vh_same_index", line_index, 10'd0);
    do_line("after_vh", 0);

    // Random keys over several fields.
    for (int f = 0; f < 6; f++) begin
      do_vsync(logic'(f & 1), 1'b1, $urandom);
      for (int l = 0; l < 3; l++) do_line("rand", 0);
      if (f == 2) do_key_load($urandom);
    end

    repeat (4) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
